// File: rtl/disp_pkg.sv
// Shared segment patterns, digit indices and the BCD-to-segment decode
// for the multiplexed 7-segment display path.
package disp_pkg;

    localparam int unsigned BCD_W  = 4;
    localparam int unsigned SEG_W  = 7;
    localparam int unsigned DIGITS = 4;

    localparam int unsigned DIG_U = 0;
    localparam int unsigned DIG_D = 1;
    localparam int unsigned DIG_C = 2;
    localparam int unsigned DIG_M = 3;

    // Active-high patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [SEG_W-1:0] SEG_0    = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1    = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2    = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3    = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4    = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5    = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6    = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7    = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8    = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9    = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_DASH = 7'h40;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } slot_state_e;

    // Non-BCD codes render as a dash so a corrupt digit is visible
    function automatic logic [SEG_W-1:0] bcd_to_seg(input logic [BCD_W-1:0] bcd);
        logic [SEG_W-1:0] pat;
        case (bcd)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_DASH;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/bcd_display_scan_if.sv
// Word inputs from the counter stage and pin-level display outputs.
interface bcd_display_scan_if;
    logic [8:0] word_lo;
    logic [8:0] word_hi;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       tag_err;

    modport master (
        output word_lo, word_hi,
        input  seg, dp, an, tag_err
    );

    modport slave (
        input  word_lo, word_hi,
        output seg, dp, an, tag_err
    );
endinterface

// File: rtl/seg7_decoder.sv
// Combinational BCD digit to active-high 7-segment pattern.
module seg7_decoder
    import disp_pkg::*;
(
    input  logic [BCD_W-1:0] bcd,
    output logic [SEG_W-1:0] seg_c
);
    assign seg_c = bcd_to_seg(bcd);
endmodule

// File: rtl/bcd_display_scan.sv
// Snapshot, scan and drive a 4-digit multiplexed 7-segment display with
// per-slot dead time and leading-zero blanking.
module bcd_display_scan
    import disp_pkg::*;
#(
    parameter int unsigned F_CLK_HZ       = 25_000_000,
    parameter int unsigned SCAN_HZ        = 1000,
    parameter int unsigned BLANK_CYC      = 64,
    parameter int unsigned SEG_ACTIVE_LOW = 1,
    parameter int unsigned AN_ACTIVE_LOW  = 1,
    parameter int unsigned LZ_BLANK       = 1,
    parameter int unsigned DP_DIGIT       = 4
) (
    input  logic          clk,
    input  logic          reset,
    bcd_display_scan_if.slave bus
);
    localparam int unsigned SLOT   = F_CLK_HZ / SCAN_HZ;
    localparam int unsigned CYC_W  = (SLOT > 1) ? $clog2(SLOT) : 1;
    localparam int unsigned DISP_W = DIGITS * BCD_W;

    localparam logic [SEG_W-1:0]  SEG_OFF = (SEG_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic              DP_OFF  = (SEG_ACTIVE_LOW != 0);
    localparam logic [DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? '1 : '0;

    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [1:0]        idx_q, idx_d;
    logic [DISP_W-1:0] shadow_q, shadow_d;
    logic [DISP_W-1:0] disp_q, disp_d;
    logic              tag_err_q, tag_err_d;
    slot_state_e       state_q, state_d;
    logic [SEG_W-1:0]  seg_q, seg_d;
    logic              dp_q, dp_d;
    logic [DIGITS-1:0] an_q, an_d;

    logic [BCD_W-1:0]  digit_c;
    logic [SEG_W-1:0]  seg_raw_c;
    logic              digit_blank_c;

    // Capture, scan counter and frame-boundary snapshot
    always_comb begin
        shadow_d  = shadow_q;
        tag_err_d = tag_err_q;
        disp_d    = disp_q;
        cyc_d     = cyc_q;
        idx_d     = idx_q;

        if (!bus.word_lo[8] && bus.word_hi[8]) begin
            shadow_d = {bus.word_hi[7:0], bus.word_lo[7:0]};
        end else begin
            tag_err_d = 1'b1;
        end

        if (cyc_q == CYC_W'(SLOT - 1)) begin
            cyc_d = '0;
            idx_d = idx_q + 2'd1;
        end else begin
            cyc_d = cyc_q + CYC_W'(1);
        end

        if (cyc_q == '0 && idx_q == 2'(DIG_U)) begin
            disp_d = shadow_q;
        end
    end

    assign digit_c = BCD_W'(disp_q >> {idx_q, 2'b00});

    // A leading digit is dark when it and every more significant digit are zero
    always_comb begin
        digit_blank_c = 1'b0;
        if (LZ_BLANK != 0) begin
            case (idx_q)
                2'(DIG_M): digit_blank_c = (disp_q[15:12] == 4'd0);
                2'(DIG_C): digit_blank_c = (disp_q[15:8]  == 8'd0);
                2'(DIG_D): digit_blank_c = (disp_q[15:4]  == 12'd0);
                default:   digit_blank_c = 1'b0;
            endcase
        end
    end

    seg7_decoder u_dec (
        .bcd   (digit_c),
        .seg_c (seg_raw_c)
    );

    // Slot FSM: dead time first, then the selected digit
    always_comb begin
        state_d = state_q;
        seg_d   = SEG_OFF;
        dp_d    = DP_OFF;
        an_d    = AN_OFF;

        case (state_q)
            ST_BLANK: if (cyc_d >= CYC_W'(BLANK_CYC)) state_d = ST_ON;
            ST_ON:    if (cyc_d <  CYC_W'(BLANK_CYC)) state_d = ST_BLANK;
            default:  state_d = ST_BLANK;
        endcase

        if (state_q == ST_ON && !digit_blank_c) begin
            an_d  = AN_OFF ^ (DIGITS'(1) << idx_q);
            seg_d = SEG_OFF ^ seg_raw_c;
            dp_d  = DP_OFF ^ (32'(idx_q) == DP_DIGIT);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q     <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            disp_q    <= '0;
            tag_err_q <= 1'b0;
            state_q   <= ST_BLANK;
            seg_q     <= SEG_OFF;
            dp_q      <= DP_OFF;
            an_q      <= AN_OFF;
        end else begin
            cyc_q     <= cyc_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            disp_q    <= disp_d;
            tag_err_q <= tag_err_d;
            state_q   <= state_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            an_q      <= an_d;
        end
    end

    assign bus.seg     = seg_q;
    assign bus.dp      = dp_q;
    assign bus.an      = an_q;
    assign bus.tag_err = tag_err_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench: SLOT=10, BLANK_CYC=2, active-low pins; t counts cycles
// since reset release, outputs at t reflect the scan position at t-1.
module tb_bcd_display_scan;

    logic clk;
    logic reset;
    int   tcyc;
    int   n_checks;
    int   n_err;

    bcd_display_scan_if bus ();

    bcd_display_scan #(
        .F_CLK_HZ  (1000),
        .SCAN_HZ   (100),
        .BLANK_CYC (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected done");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0d)", tag, got, exp, tcyc);
        end
    endtask

    task automatic adv(input int target);
        while (tcyc < target) begin
            @(posedge clk);
            #1;
            tcyc++;
        end
    endtask

    task automatic chk_disp(input string tag, input logic [3:0] an_exp, input logic [6:0] seg_exp);
        chk({tag, "_an"},  16'(bus.an),  16'(an_exp));
        chk({tag, "_seg"}, 16'(bus.seg), 16'(seg_exp));
    endtask

    initial begin
        n_checks    = 0;
        n_err       = 0;
        tcyc        = 0;
        reset       = 1'b1;
        bus.word_lo = 9'h000;
        bus.word_hi = 9'h100;

        repeat (3) @(posedge clk);
        #1;
        chk_disp("rst", 4'hF, 7'h7F);
        chk("rst_dp",  16'(bus.dp),      16'h1);
        chk("rst_tag", 16'(bus.tag_err), 16'h0);

        reset = 1'b0;
        tcyc  = 0;
        adv(1);  chk("zero_c0_an", 16'(bus.an), 16'hF);
        adv(2);  chk("zero_c1_an", 16'(bus.an), 16'hF);
        adv(3);  chk_disp("zero_u_on", 4'hE, 7'h40);
        chk("zero_dp", 16'(bus.dp), 16'h1);
        adv(10); chk("zero_u_end_an", 16'(bus.an), 16'hE);
        adv(11); chk("slot1_blank_an", 16'(bus.an), 16'hF);
        adv(13); chk("lz_d_an", 16'(bus.an), 16'hF);
        adv(23); chk("lz_c_an", 16'(bus.an), 16'hF);
        adv(33); chk("lz_m_an", 16'(bus.an), 16'hF);

        adv(35);
        bus.word_lo = 9'h034;
        bus.word_hi = 9'h112;
        adv(45); chk_disp("n1234_u", 4'hE, 7'h19);
        adv(55); chk_disp("n1234_d", 4'hD, 7'h30);
        adv(65); chk_disp("n1234_c", 4'hB, 7'h24);
        adv(75); chk_disp("n1234_m", 4'h7, 7'h79);

        adv(76);
        bus.word_lo = 9'h0A0;
        adv(85); chk_disp("dash_u0", 4'hE, 7'h40);
        adv(95); chk_disp("dash_d",  4'hD, 7'h3F);

        adv(103);
        bus.word_lo = 9'h056;
        bus.word_hi = 9'h178;
        adv(105); chk_disp("tear_c_old", 4'hB, 7'h24);
        adv(115); chk_disp("tear_m_old", 4'h7, 7'h79);
        adv(125); chk_disp("new_u6", 4'hE, 7'h02);
        adv(135); chk_disp("new_d5", 4'hD, 7'h12);
        adv(145); chk_disp("new_c8", 4'hB, 7'h00);
        adv(155); chk_disp("new_m7", 4'h7, 7'h78);
        chk("tag_clean", 16'(bus.tag_err), 16'h0);

        adv(156);
        bus.word_lo = 9'h105;
        adv(157);
        bus.word_lo = 9'h056;
        chk("tag_set", 16'(bus.tag_err), 16'h1);
        adv(165); chk_disp("tag_hold_u", 4'hE, 7'h02);
        adv(170); chk("tag_sticky", 16'(bus.tag_err), 16'h1);

        adv(175);
        chk_disp("pre_rst_d", 4'hD, 7'h12);
        reset = 1'b1;
        adv(176);
        chk_disp("mid_rst", 4'hF, 7'h7F);
        chk("mid_rst_tag", 16'(bus.tag_err), 16'h0);
        chk("mid_rst_dp",  16'(bus.dp),      16'h1);

        reset = 1'b0;
        tcyc  = 0;
        adv(1);  chk("rs_c0_an", 16'(bus.an), 16'hF);
        adv(2);  chk("rs_c1_an", 16'(bus.an), 16'hF);
        adv(3);  chk_disp("rs_u_zero", 4'hE, 7'h40);
        adv(13); chk("rs_lz_d_an", 16'(bus.an), 16'hF);
        adv(43); chk_disp("rs_u6", 4'hE, 7'h02);
        adv(53); chk_disp("rs_d5", 4'hD, 7'h12);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/bcd_display_scan.md
Name: bcd_display_scan

Overview:
- Consumes the packed BCD words produced by the 4-digit up/down counter stage.
  - word_lo = {0, D, U}
  - word_hi = {1, M, C}
- Drives a 4-digit, time-multiplexed 7-segment display.
- Checks the tag bits, captures a tear-free snapshot once per scan frame, blanks leading zeros and inserts dead time between digits to suppress ghosting.

Parameters:
- F_CLK_HZ, 25_000_000: clk frequency in Hz.
- SCAN_HZ, 1000: per-digit slot rate. SLOT = F_CLK_HZ/SCAN_HZ cycles; must satisfy SLOT > BLANK_CYC.
- BLANK_CYC, 64: dead-time cycles at the start of each slot.
- SEG_ACTIVE_LOW, 1: 1 inverts seg and dp at the pins.
- AN_ACTIVE_LOW, 1: 1 inverts an at the pins.
- LZ_BLANK, 1: 1 enables leading-zero blanking.
- DP_DIGIT, 4: digit index 0..3 whose dp is lit; 4 means dp is never lit.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- word_lo  in  9  {tag=0, D[3:0], U[3:0]}, same clock domain
- word_hi  in  9  {tag=1, M[3:0], C[3:0]}, same clock domain
- seg  out  7  {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
- dp  out  1  decimal point, polarity per SEG_ACTIVE_LOW
- an  out  4  digit enables; an[0]=U .. an[3]=M; polarity per AN_ACTIVE_LOW
- tag_err  out  1  sticky tag-violation flag

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high. Inputs need no synchronizer.
- Reset, on the clock edge with reset=1:
  - shadow and disp cleared to 0000.
  - slot counter = 0, digit index = 0, tag_err = 0.
  - Registered outputs take their inactive values: an = all off, seg = all off, dp = off.
  - Reset asserted mid-slot blanks the outputs on the next edge.
- Capture, every cycle:
  - If word_lo[8]==0 and word_hi[8]==1: shadow <= {word_hi[7:0], word_lo[7:0]}.
  - Otherwise shadow holds and tag_err <= 1. tag_err stays set until reset.
- Scan counter:
  - cyc counts 0..SLOT-1 and then wraps.
  - On wrap, digit index advances 0→1→2→3→0.
  - Frame boundary = cyc==0 with digit index 0. At that point disp <= shadow (the shadow value as of the previous cycle).
  - Changes arriving mid-frame therefore appear only at the next frame boundary, so no digit tearing.
- Per-slot state machine (two states, same for each digit):
  - BLANK state, cyc < BLANK_CYC: all anodes off, segments off, dp off.
  - ON state, cyc ≥ BLANK_CYC: only an[idx] active, seg = decode(disp digit idx), dp active iff idx==DP_DIGIT.
- Output timing: all outputs are registered. The value computed from cyc/idx on cycle n appears on cycle n+1, a fixed 1-cycle latency.
- Leading-zero blanking, with LZ_BLANK=1 (blanked digit keeps its anode off for the whole slot):
  - M is blanked if M==0.
  - C is blanked if M==0 and C==0.
  - D is blanked if M==C==D==0.
  - U is never blanked.
- Decode, active-high before the polarity inversion:
  - 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07, 8:7F, 9:6F.
  - Invalid BCD values 10..15 show a dash, 40. A dash digit is non-zero for blanking purposes.
- Frame period = 4*SLOT cycles. Duty per digit = (SLOT-BLANK_CYC)/(4*SLOT).

Decomposition:
- Package disp_pkg:
  - Segment pattern constants SEG_0..SEG_9 and SEG_DASH.
  - Function bcd_to_seg(4-bit) returning a 7-bit active-high pattern.
  - Digit index localparams DIG_U, DIG_D, DIG_C, DIG_M.
- Sub-module seg7_decoder: combinational, 4-bit in → 7-bit out, wraps bcd_to_seg.
- bcd_display_scan holds the capture logic, scan counter, state machine, blanking and output registers.

Test Plan:
Bench parameters: F_CLK_HZ=1000, SCAN_HZ=100 (SLOT=10), BLANK_CYC=2, both polarities active-low.
- Reset, then release with word_lo=9'h000 and word_hi=9'h100:
  - During reset: an=4'hF, seg=7'h7F, tag_err=0.
  - Slot 0, cycles 0..1: blanked.
  - From cycle 2 plus 1 cycle of latency: an=4'hE, seg=7'h40.
  - Slots 1..3: an=4'hF (leading zeros blanked).
- Apply word_lo=9'h034 and word_hi=9'h112 → from the next frame:
  - Slot 0: seg=7'h19 (4).
  - Slot 1: seg=7'h30 (3).
  - Slot 2: seg=7'h24 (2).
  - Slot 3: seg=7'h79 (1), an=4'h7.
- Apply word_lo=9'h0A0 → slot 1 seg=7'h3F (dash); slot 0 seg=7'h40 (0).
- Apply word_lo=9'h105 for 1 cycle → tag_err=1 on the next cycle; display keeps its prior value; tag_err stays 1 until reset.
- Change the words during slot 2 → slots 2 and 3 of the current frame keep the old digits; new digits appear from slot 0 of the next frame.
- Assert reset at cycle 5 of slot 1 → next edge: an=4'hF and seg=7'h7F; the scan restarts at slot 0, cycle 0 after release.
